// File: rtl/debounce_pkg.sv
// Shared types and default sizing for the debounce_sync input conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d_async};
    end
  end

  assign d_sync = chain[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise a raw level, debounce it by consecutive agreement, and emit a clean
// level plus registered one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt, q_nxt, busy_nxt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_async(din),
    .d_sync (s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (set) begin
      // Forced high: no pulse, any pending qualification is dropped.
      state_nxt = STABLE_HI;
      cnt_nxt   = '0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = STABLE_HI;
              rise_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = WAIT_HI;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt = STABLE_HI;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_nxt = STABLE_LO;
              fall_nxt  = 1'b1;
              cnt_nxt   = '0;
            end else begin
              state_nxt = WAIT_LO;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else if (cnt >= CNT_LAST) begin
            state_nxt = STABLE_LO;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered copies decoded from the next state.
  always_comb begin
    q_nxt    = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
    busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= STABLE_LO;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: run-length reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_debounce_sync;

  localparam int SS = 2;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic set = 1'b1;
  logic din = 1'b1;
  logic q, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .set (set),
    .din (din),
    .q   (q),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: delay din by SS samples, then count consecutive samples that disagree
  // with the current level; flip once the run reaches DC.
  bit m_hist[SS];
  bit m_q, m_rise, m_fall, m_busy;
  int m_run;

  always @(posedge clk) begin
    bit s_cur;
    if (!rst) begin
      foreach (m_hist[i]) m_hist[i] = 1'b0;
      m_q = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_run = 0;
    end else begin
      s_cur = m_hist[SS-1];
      for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = din;
      m_rise = 0;
      m_fall = 0;
      if (set) begin
        m_q   = 1;
        m_run = 0;
      end else if (s_cur != m_q) begin
        m_run++;
        if (m_run >= DC) begin
          m_q = s_cur;
          if (s_cur) m_rise = 1;
          else       m_fall = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0);
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q",    q,    m_q);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_busy", busy, m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with set and din both high: reset must dominate.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1;
      check("reset_q",    q,    1'b0);
      check("reset_rise", rise, 1'b0);
      check("reset_fall", fall, 1'b0);
      check("reset_busy", busy, 1'b0);
    end

    rst = 1; set = 0; din = 0;
    repeat (6) tick();

    // Clean rise: after edge Ei.
    din = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rise_q",     q,    (i >= 5));
      check("rise_pulse", rise, (i == 5));
      check("rise_busy",  busy, (i >= 2 && i <= 4));
      check("rise_fall",  fall, 1'b0);
    end

    // Glitch of three samples must not reach q.
    din = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) din = 1;
      tick();
      check("glitch_q",    q,    1'b1);
      check("glitch_fall", fall, 1'b0);
    end
    check("glitch_busy", busy, 1'b0);

    // Clean fall.
    din = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fall_q",     q,    (i < 5));
      check("fall_pulse", fall, (i == 5));
      check("fall_rise",  rise, 1'b0);
    end

    // Set override from q=0, then release with din low.
    set = 1;
    tick();
    check("set_q",    q,    1'b1);
    check("set_rise", rise, 1'b0);
    check("set_busy", busy, 1'b0);
    set = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("setrel_q",    q,    (k < 4));
      check("setrel_fall", fall, (k == 4));
    end

    // Reset in the middle of a rise qualification.
    din = 1;
    repeat (3) tick();
    check("mid_busy", busy, 1'b1);
    rst = 0;
    tick();
    check("mid_rst_q",    q,    1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("mid_q",    q,    (k == 6));
      check("mid_rise", rise, (k == 6));
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
